// File: rtl/mcu_key_ctrl.sv
// -----------------------------------------------------------------------------
// mcu_key_ctrl
//   Key front-end for a small game controller. Raw keys are synchronized and
//   debounced. A three-state game FSM (IDLE / RUN / PAUSE) is driven by the
//   start key. One-cycle move pulses are produced from the direction keys,
//   with frame-tick based auto-repeat while a key is held in RUN.
//
// Ports
//   CLK           system clock (same domain as the AHB bus clock)
//   RST           synchronous active-high reset
//   u_btn[1:0]    raw direction keys, [0] left, [1] right, 1 = pressed
//   u_str         raw start/pause key, 1 = pressed
//   u_sw[1:0]     switch levels, [0] selects fast repeat, [1] ignored
//   frame_tick    one-cycle pulse per video frame
//   mv_left       one-cycle move-left pulse
//   mv_right      one-cycle move-right pulse
//   game_run      level, 1 while the FSM is in RUN
//   game_restart  one-cycle pulse on PAUSE -> IDLE restart
//   key_state     current FSM state encoding
// -----------------------------------------------------------------------------
module mcu_key_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 8,
  parameter int REP_RATE   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] u_btn,
  input  logic       u_str,
  input  logic [1:0] u_sw,
  input  logic       frame_tick,
  output logic       mv_left,
  output logic       mv_right,
  output logic       game_run,
  output logic       game_restart,
  output logic [1:0] key_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] DELAY_T   = 8'(REP_DELAY);
  localparam logic [7:0] RATE_SLOW = 8'(REP_RATE);
  localparam logic [7:0] RATE_FAST = 8'(REP_RATE / 2);

  // Key vector: [0] left, [1] right, [2] start.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_prev;
  logic [2:0] press;
  logic [7:0] deb_cnt [3];

  logic       both;
  state_t     state;
  state_t     state_nxt;
  logic       restart_nxt;
  logic       run_nxt;

  logic [7:0] rep_cnt  [2];
  logic [7:0] rep_rate [2];
  logic [7:0] tgt      [2];
  logic [1:0] rep_phase;
  logic [1:0] held;
  logic [1:0] fire;
  logic       mv_l_nxt;
  logic       mv_r_nxt;

  logic       unused_sw;

  assign raw       = {u_str, u_btn};
  // deb_prev lags deb by one cycle, so an edge is seen in the cycle after
  // the debounced flip; clearing deb_prev on reset makes a key held through
  // reset look like a fresh press.
  assign press     = deb & ~deb_prev;
  assign both      = deb[0] & deb[1];
  assign run_nxt   = (state_nxt == RUN);
  assign key_state = state;
  assign unused_sw = u_sw[1];

  // Two-flop synchronizers plus per-key debounce counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= 3'b000;
      sync2    <= 3'b000;
      deb      <= 3'b000;
      deb_prev <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        deb_cnt[k] <= 8'd0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] != deb[k]) begin
          // The flip happens on the cycle the count would reach DEB_CYCLES.
          if (deb_cnt[k] >= DEB_LAST) begin
            deb[k]     <= sync2[k];
            deb_cnt[k] <= 8'd0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 8'd1;
          end
        end else begin
          deb_cnt[k] <= 8'd0;
        end
      end
    end
  end

  // Game FSM next-state logic; restart only from PAUSE with both keys down.
  always_comb begin
    state_nxt   = state;
    restart_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press[2]) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (press[2]) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
        end
      end
      PAUSE: begin
        if (press[2] && both) begin
          state_nxt   = IDLE;
          restart_nxt = 1'b1;
        end else if (press[2]) begin
          state_nxt = RUN;
        end else begin
          state_nxt = PAUSE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Game FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Repeat qualification: a key counts only while held alone and the game
  // will be running; a press event restarts the count, swallowing any tick.
  always_comb begin
    held = 2'b00;
    fire = 2'b00;
    for (int d = 0; d < 2; d++) begin
      tgt[d]  = rep_phase[d] ? rep_rate[d] : DELAY_T;
      held[d] = deb[d] & ~both & run_nxt;
      if (held[d] && !press[d] && frame_tick && (rep_cnt[d] == (tgt[d] - 8'd1))) begin
        fire[d] = 1'b1;
      end else begin
        fire[d] = 1'b0;
      end
    end
  end

  // Repeat tick counters; the repeat interval is latched at every pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_phase <= 2'b00;
      for (int d = 0; d < 2; d++) begin
        rep_cnt[d]  <= 8'd0;
        rep_rate[d] <= 8'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!held[d] || press[d]) begin
          rep_cnt[d]   <= 8'd0;
          rep_phase[d] <= 1'b0;
        end else if (fire[d]) begin
          rep_cnt[d]   <= 8'd0;
          rep_phase[d] <= 1'b1;
          rep_rate[d]  <= u_sw[0] ? RATE_FAST : RATE_SLOW;
        end else if (frame_tick && (rep_cnt[d] != 8'hFF)) begin
          rep_cnt[d] <= rep_cnt[d] + 8'd1;
        end
      end
    end
  end

  // Move pulse selection; left wins the (unreachable) tie as a hard guard.
  always_comb begin
    mv_l_nxt = run_nxt & ~both & (press[0] | fire[0]);
    mv_r_nxt = run_nxt & ~both & (press[1] | fire[1]) & ~mv_l_nxt;
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mv_left      <= 1'b0;
      mv_right     <= 1'b0;
      game_run     <= 1'b0;
      game_restart <= 1'b0;
    end else begin
      mv_left      <= mv_l_nxt;
      mv_right     <= mv_r_nxt;
      game_run     <= run_nxt;
      game_restart <= restart_nxt;
    end
  end

endmodule
